seq_cla_adder_64: RTL and testbench
===================================

# seq_cla_adder_64

Multi-word sequential adder that streams wide operands through a single `carry_look_ahead_16bit` instance, one 16-bit slice per clock, rippling the carry through a register. It is the operand-feeding and result-collecting stage wrapped around the 16-bit CLA. It provides a 64-bit (parameterisable) add with a valid/ready handshake at the cost of WORDS cycles of latency.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit slices. Legal range is 1..8. Operand width is 16*WORDS.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and carry-in valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  16*WORDS  operand A, captured on acceptance.
- `b`  in  16*WORDS  operand B, captured on acceptance.
- `c_in`  in  1  carry into slice 0, captured on acceptance.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  16*WORDS  registered sum.
- `c_out`  out  1  carry out of the top slice.
- `ovf`  out  1  two's-complement overflow of the full-width add.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Exactly one `carry_look_ahead_16bit` instance. Its inputs are driven by slice `idx` of the captured A and B plus `carry_reg`.
- States:
  - IDLE:
    - `in_ready`=1.
    - `in_valid` high captures `a`, `b` and `c_in` (into `carry_reg`), sets `idx`=0, and moves to RUN.
  - RUN, each cycle:
    - write the CLA sum into `sum[16*idx +: 16]`;
    - set `carry_reg` to the CLA `c_out`;
    - increment `idx`.
    - On the slice where `idx`==WORDS-1, also register `c_out` and `ovf`, then go to DONE.
  - DONE:
    - `out_valid`=1. `sum`, `c_out` and `ovf` are held stable.
    - `out_ready` high moves to IDLE.
- `ovf` = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), using the captured operands.
- Arithmetic:
  - {`c_out`,`sum`} = A + B + `c_in`, modulo 2^(16*WORDS+1).
  - No saturation.
- No overlap: a new transaction is not accepted while in RUN or DONE. `in_valid` outside IDLE is ignored.
- Operands changing on the input ports after acceptance have no effect.
- `sum` slices not yet written in RUN retain their previous values. Consumers use them only when `out_valid` is high.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `sum`=0, `c_out`=0, `ovf`=0.
  - `idx`=0, `carry_reg`=0.
- Latency:
  - Acceptance edge E0.
  - Slice k is registered at edge E(k+1).
  - `out_valid` is high after edge E_WORDS, i.e. WORDS cycles after acceptance.
- Throughput:
  - One add per WORDS+2 cycles minimum: accept, WORDS RUN cycles, a DONE cycle with `out_ready` already high, and a return to IDLE.
  - `in_ready` rises in the cycle after the DONE handshake. It is not combinationally tied to `out_ready`.
- `out_ready` held low keeps DONE indefinitely, with outputs frozen.
- The single-cycle combinational path is one 16-bit CLA plus the slice mux. No path spans multiple slices.
- `rst` in any state returns to IDLE on the next edge and clears all outputs. An in-flight transaction is discarded and produces no `out_valid`.
- `rst` and `in_valid` high together: reset wins and no capture occurs.
- WORDS=1: RUN lasts one cycle, and `out_valid` is high one cycle after acceptance.

## Test plan
- **Basic add:** `a`=0x0000_0000_0000_0001, `b`=0x0000_0000_0000_0002, `c_in`=0.
  - `out_valid` 4 cycles after acceptance.
  - `sum`=0x…0003, `c_out`=0, `ovf`=0.
- **Full carry ripple:** `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0, `c_in`=1.
  - `sum`=0, `c_out`=1, `ovf`=0.
  - Confirms the carry crosses all 3 slice boundaries via `carry_reg`.
- **Signed overflow:** `a`=0x7FFF_FFFF_FFFF_FFFF, `b`=1, `c_in`=0.
  - `sum`=0x8000_0000_0000_0000, `c_out`=0, `ovf`=1.
- **Backpressure and input stability:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid`.
    - Outputs are stable and `in_ready`=0.
    - `in_valid` pulses with new operands are ignored.
  - Raise `out_ready`: `in_ready`=1 on the next cycle.
- **Reset mid-operation:**
  - Assert `rst` for 1 cycle at the second RUN cycle.
    - All outputs return to reset values and `out_valid` never rises.
  - Next transaction 0x1234 + 0x4321 gives `sum`=0x5555.
- **Random back-to-back:** 1000 random (`a`,`b`,`c_in`) with random `out_ready` delays.
  - Compare {`c_out`,`sum`} against the 65-bit reference sum.
  - Also run with WORDS=1 and WORDS=8.

Source files
------------

// File: rtl/seq_cla_adder_64.sv
// Sequential multi-word adder: streams 16-bit slices of wide operands through one
// 16-bit carry-lookahead adder, rippling the carry between slices through a register.

module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Second lookahead level: group carries come straight from c_in, not from each other.
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
            (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    sum   = p ^ c;
    c_out = gc[4];
  end
endmodule

module seq_cla_adder_64 #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  c_out,
  output logic                  ovf,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, neither depends on the other side.
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [15:0]     slice_a, slice_b, cla_sum;
  logic            cla_c, last;

  assign slice_a = a_q[16*idx_q +: 16];
  assign slice_b = b_q[16*idx_q +: 16];
  assign last    = (idx_q == IW'(WORDS - 1));

  carry_look_ahead_16bit u_cla (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (cla_sum),
    .c_out (cla_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    dbg_state = state_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      sum_d[16*idx_q +: 16] = cla_sum;
      carry_d = cla_c;
      idx_d   = idx_q + 1'b1;
      if (last) begin
        c_out_d = cla_c;
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[15] != a_q[W-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_seq_cla_adder_64.sv
// Bench for seq_cla_adder_64 at WORDS = 1, 4 and 8; one instance is selected per transaction
// and results are checked against a plain-arithmetic reference sum.

module tb_seq_cla_adder_64;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] a_i = '0, b_i = '0;
  logic         c_i = 1'b0;
  int           sel = 1;
  int           cur_words = 4;

  int n_cmp = 0;
  int n_err = 0;
  logic [129:0] exp_q[$];

  logic         in_ready_1, out_valid_1, c_out_1, ovf_1, busy_1;
  logic         in_ready_4, out_valid_4, c_out_4, ovf_4, busy_4;
  logic         in_ready_8, out_valid_8, c_out_8, ovf_8, busy_8;
  logic [15:0]  sum_1;
  logic [63:0]  sum_4;
  logic [127:0] sum_8;
  logic [1:0]   dbg_1, dbg_4, dbg_8;

  logic         in_ready_s, out_valid_s, c_out_s, ovf_s, busy_s;
  logic [127:0] sum_s;

  always #5 clk = ~clk;

  seq_cla_adder_64 #(.WORDS(1)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(in_ready_1),
    .a(a_i[15:0]), .b(b_i[15:0]), .c_in(c_i), .out_valid(out_valid_1),
    .out_ready(out_ready && sel == 0), .sum(sum_1), .c_out(c_out_1), .ovf(ovf_1),
    .busy(busy_1), .dbg_state(dbg_1));

  seq_cla_adder_64 #(.WORDS(4)) dut_4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(in_ready_4),
    .a(a_i[63:0]), .b(b_i[63:0]), .c_in(c_i), .out_valid(out_valid_4),
    .out_ready(out_ready && sel == 1), .sum(sum_4), .c_out(c_out_4), .ovf(ovf_4),
    .busy(busy_4), .dbg_state(dbg_4));

  seq_cla_adder_64 #(.WORDS(8)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(in_ready_8),
    .a(a_i), .b(b_i), .c_in(c_i), .out_valid(out_valid_8),
    .out_ready(out_ready && sel == 2), .sum(sum_8), .c_out(c_out_8), .ovf(ovf_8),
    .busy(busy_8), .dbg_state(dbg_8));

  always_comb begin
    in_ready_s = in_ready_4; out_valid_s = out_valid_4; c_out_s = c_out_4;
    ovf_s = ovf_4; busy_s = busy_4; sum_s = {64'd0, sum_4};
    if (sel == 0) begin
      in_ready_s = in_ready_1; out_valid_s = out_valid_1; c_out_s = c_out_1;
      ovf_s = ovf_1; busy_s = busy_1; sum_s = {112'd0, sum_1};
    end else if (sel == 2) begin
      in_ready_s = in_ready_8; out_valid_s = out_valid_8; c_out_s = c_out_8;
      ovf_s = ovf_8; busy_s = busy_8; sum_s = sum_8;
    end
  end

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (WORDS=%0d): got %0h expected %0h", tag, cur_words, got, exp);
    end
  endtask

  // Reference: wide-integer sum truncated to the operand width plus one carry bit.
  function automatic logic [129:0] model(input logic [127:0] x, input logic [127:0] y,
                                         input logic ci, input int words);
    int           w;
    logic [128:0] m, full;
    logic [127:0] s, xm, ym;
    logic         co, ov;
    w    = 16 * words;
    m    = (129'd1 << w) - 129'd1;
    xm   = x & m[127:0];
    ym   = y & m[127:0];
    full = {1'b0, xm} + {1'b0, ym} + {128'd0, ci};
    s    = full[127:0] & m[127:0];
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic select(input int s);
    sel = s;
    cur_words = (s == 0) ? 1 : (s == 1) ? 4 : 8;
  endtask

  task automatic run_txn(input logic [127:0] ta, input logic [127:0] tb_v, input logic tc,
                         input int hold, input bit pulse);
    logic [129:0] exp;
    int           lat;
    exp_q.push_back(model(ta, tb_v, tc, cur_words));
    lat = 0;
    while (!in_ready_s && lat < 50) begin @(posedge clk); #1; lat++; end
    check("in_ready_idle", {129'd0, in_ready_s}, 130'd1);
    a_i = ta; b_i = tb_v; c_i = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = rand128(); b_i = rand128(); c_i = ~tc;
    lat = 0;
    while (!out_valid_s && lat < 100) begin @(posedge clk); #1; lat++; end
    check("latency", 130'(lat), 130'(cur_words));
    exp = exp_q.pop_front();
    check("sum", {2'b00, sum_s}, {2'b00, exp[127:0]});
    check("c_out", {129'd0, c_out_s}, {129'd0, exp[128]});
    check("ovf", {129'd0, ovf_s}, {129'd0, exp[129]});
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin in_valid = 1'b1; a_i = rand128(); b_i = rand128(); end
      @(posedge clk); #1;
      check("hold_out_valid", {129'd0, out_valid_s}, 130'd1);
      check("hold_in_ready", {129'd0, in_ready_s}, 130'd0);
      check("hold_result", {ovf_s, c_out_s, sum_s}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_ack", {129'd0, in_ready_s}, 130'd1);
    check("out_valid_after_ack", {129'd0, out_valid_s}, 130'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [127:0] ra, rb;

    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      select(s);
      #1;
      check("rst_in_ready", {129'd0, in_ready_s}, 130'd1);
      check("rst_out_valid", {129'd0, out_valid_s}, 130'd0);
      check("rst_busy", {129'd0, busy_s}, 130'd0);
      check("rst_result", {ovf_s, c_out_s, sum_s}, 130'd0);
    end

    select(1);
    run_txn(128'h1, 128'h2, 1'b0, 0, 1'b0);
    run_txn(128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, 0, 1'b0);
    run_txn(128'h7FFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 0, 1'b0);
    run_txn(128'h0123_4567_89AB_CDEF, 128'hFEDC_BA98_7654_3210, 1'b1, 5, 1'b1);

    // Reset during the second RUN cycle discards the transaction.
    a_i = 128'hDEAD_BEEF_0000_FFFF; b_i = 128'h1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_in_ready", {129'd0, in_ready_s}, 130'd1);
    check("midrst_busy", {129'd0, busy_s}, 130'd0);
    check("midrst_result", {ovf_s, c_out_s, sum_s}, 130'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_s) seen = 1'b1;
    end
    check("midrst_no_valid", {129'd0, seen}, 130'd0);
    run_txn(128'h1234, 128'h4321, 1'b0, 0, 1'b0);
    check("post_rst_sum", {2'b00, sum_s}, 130'h5555);

    // Reset wins over a simultaneous in_valid.
    rst = 1'b1; in_valid = 1'b1; a_i = 128'h5;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_busy", {129'd0, busy_s}, 130'd0);
    check("rst_vs_valid_in_ready", {129'd0, in_ready_s}, 130'd1);

    for (int s = 0; s < 3; s++) begin
      select(s);
      n = (s == 1) ? 1000 : 200;
      for (int t = 0; t < n; t++) begin
        ra = rand128();
        rb = ($urandom_range(0, 7) == 0) ? ~ra : rand128();
        run_txn(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
